// File: rtl/seg7_pair_decoder_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pair_decoder_pkg
// Definitions shared by the seven-segment receive path and the display driver:
// segment patterns (bit6=A ... bit0=G, active-high), the decoder FSM state
// type and the default settle time.
// -----------------------------------------------------------------------------
package seg7_pair_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int DEFAULT_STABLE_CYCLES = 16;

  typedef enum logic [1:0] {
    SETTLE,
    DECODE,
    HOLD
  } decodeState_t;

endpackage

// File: rtl/seg7_pair_decoder_digit_lookup.sv
// -----------------------------------------------------------------------------
// seg7_digit_lookup
// Purely combinational reverse lookup of one seven-segment pattern.
//   i_pattern    : segments A..G (bit6..bit0), active-high
//   i_allowBlank : when set, an all-off pattern is legal and reads as 0
//   o_digit      : decoded BCD digit (0 when illegal)
//   o_legal      : pattern is one of the shared digit encodings
// -----------------------------------------------------------------------------
module seg7_digit_lookup
  import seg7_pair_decoder_pkg::*;
(
  input  logic [6:0] i_pattern,
  input  logic       i_allowBlank,
  output logic [3:0] o_digit,
  output logic       o_legal
);

  // Exact-match table; anything not listed is reported illegal.
  always_comb begin
    o_digit = 4'd0;
    o_legal = 1'b1;
    case (i_pattern)
      SEG_0:     o_digit = 4'd0;
      SEG_1:     o_digit = 4'd1;
      SEG_2:     o_digit = 4'd2;
      SEG_3:     o_digit = 4'd3;
      SEG_4:     o_digit = 4'd4;
      SEG_5:     o_digit = 4'd5;
      SEG_6:     o_digit = 4'd6;
      SEG_7:     o_digit = 4'd7;
      SEG_8:     o_digit = 4'd8;
      SEG_9:     o_digit = 4'd9;
      SEG_BLANK: o_legal = i_allowBlank;
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_pair_decoder.sv
// -----------------------------------------------------------------------------
// seg7_pair_decoder
// Receives two asynchronous seven-segment buses, waits until both have been
// stable for STABLE_CYCLES samples, then reports the decoded two-digit value.
//   clock, reset : system clock, synchronous active-high reset
//   seg_msd_in   : tens-digit segments (blank allowed = leading zero)
//   seg_lsd_in   : units-digit segments
//   msd_out      : registered tens digit (BCD)
//   lsd_out      : registered units digit (BCD)
//   value_out    : registered msd*10 + lsd
//   valid_out    : one-cycle pulse, new legal value captured
//   error_out    : one-cycle pulse, stable but illegal pattern seen
// -----------------------------------------------------------------------------
module seg7_pair_decoder
  import seg7_pair_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg_msd_in,
  input  logic [6:0] seg_lsd_in,
  output logic [3:0] msd_out,
  output logic [3:0] lsd_out,
  output logic [6:0] value_out,
  output logic       valid_out,
  output logic       error_out
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

  // Both digits travel together as {msd, lsd} through the synchronizer.
  logic [13:0]      r_sync1;
  logic [13:0]      r_sync2;
  logic [13:0]      r_prev;
  logic [13:0]      r_lastRpt;
  logic             r_rptVld;
  logic [CNT_W-1:0] r_count;
  decodeState_t     r_state;

  logic             w_changed;
  logic [CNT_W-1:0] w_countNext;
  decodeState_t     w_stateNext;
  logic [3:0]       w_msdDigit;
  logic [3:0]       w_lsdDigit;
  logic             w_msdLegal;
  logic             w_lsdLegal;
  logic             w_isRepeat;
  logic             w_doValid;
  logic             w_doError;
  logic [6:0]       w_value;

  // Two-flop synchronizer plus a one-cycle history used for change detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {seg_msd_in, seg_lsd_in};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_changed   = (r_sync2 != r_prev);
  assign w_countNext = w_changed ? '0 :
                       (r_count == STABLE_C) ? r_count : r_count + 1'b1;

  // Stability counter: restarts on any change and saturates at the target.
  always_ff @(posedge clock) begin
    if (reset) r_count <= '0;
    else       r_count <= w_countNext;
  end

  // Decode lookups work on r_prev, which holds the pattern that was counted.
  seg7_digit_lookup u_msdLookup (
    .i_pattern    (r_prev[13:7]),
    .i_allowBlank (1'b1),
    .o_digit      (w_msdDigit),
    .o_legal      (w_msdLegal)
  );

  seg7_digit_lookup u_lsdLookup (
    .i_pattern    (r_prev[6:0]),
    .i_allowBlank (1'b0),
    .o_digit      (w_lsdDigit),
    .o_legal      (w_lsdLegal)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= SETTLE;
    else       r_state <= w_stateNext;
  end

  // SETTLE leaves as the counter lands on the target so DECODE follows
  // immediately. HOLD also exits if the counter is not saturated, which
  // catches a change that slipped in during the DECODE cycle.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      SETTLE: if (w_countNext == STABLE_C) w_stateNext = DECODE;
      DECODE: w_stateNext = HOLD;
      HOLD:   if (w_changed || (r_count != STABLE_C)) w_stateNext = SETTLE;
      default: w_stateNext = SETTLE;
    endcase
  end

  // Report decisions: a repeat of the last reported pattern stays silent.
  always_comb begin
    w_isRepeat = r_rptVld && (r_prev == r_lastRpt);
    w_doValid  = 1'b0;
    w_doError  = 1'b0;
    if ((r_state == DECODE) && !w_isRepeat) begin
      w_doValid = w_msdLegal && w_lsdLegal;
      w_doError = !(w_msdLegal && w_lsdLegal);
    end
  end

  // msd*10 as msd*8 + msd*2; digits never exceed 9 so 7 bits suffice.
  assign w_value = {w_msdDigit, 3'b000} + {2'b00, w_msdDigit, 1'b0} + {3'b000, w_lsdDigit};

  // Output and report-history registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      msd_out   <= '0;
      lsd_out   <= '0;
      value_out <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
      r_lastRpt <= '0;
      r_rptVld  <= 1'b0;
    end else begin
      valid_out <= w_doValid;
      error_out <= w_doError;
      if (w_doValid) begin
        msd_out   <= w_msdDigit;
        lsd_out   <= w_lsdDigit;
        value_out <= w_value;
      end
      if (r_state == DECODE) begin
        r_lastRpt <= r_prev;
        r_rptVld  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_pair_decoder
// Directed scenarios for the two-digit seven-segment receiver with
// STABLE_CYCLES=16; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_seg7_pair_decoder;

  localparam logic [6:0] P0  = 7'b1111110;
  localparam logic [6:0] P1  = 7'b0110000;
  localparam logic [6:0] P2  = 7'b1101101;
  localparam logic [6:0] P3  = 7'b1111001;
  localparam logic [6:0] P4  = 7'b0110011;
  localparam logic [6:0] P5  = 7'b1011011;
  localparam logic [6:0] P7  = 7'b1110000;
  localparam logic [6:0] P9  = 7'b1110011;
  localparam logic [6:0] PBL = 7'b0000000;
  localparam logic [6:0] PBAD = 7'b1010101;
  localparam int LATENCY = 19;

  logic       clock;
  logic       reset;
  logic [6:0] seg_msd_in;
  logic [6:0] seg_lsd_in;
  logic [3:0] msd_out;
  logic [3:0] lsd_out;
  logic [6:0] value_out;
  logic       valid_out;
  logic       error_out;

  int checks;
  int errors;
  int bothCount;

  seg7_pair_decoder #(
    .STABLE_CYCLES (16),
    .CNT_W         (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .seg_msd_in (seg_msd_in),
    .seg_lsd_in (seg_lsd_in),
    .msd_out    (msd_out),
    .lsd_out    (lsd_out),
    .value_out  (value_out),
    .valid_out  (valid_out),
    .error_out  (error_out)
  );

  // Free-running 100 MHz clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Change both buses just after a falling edge; the next rising edge is edge 0.
  task automatic applyStimulus(input logic [6:0] msd, input logic [6:0] lsd);
    @(negedge clock);
    seg_msd_in = msd;
    seg_lsd_in = lsd;
  endtask

  // Step n edges, sampling 1 ns after each and tallying pulses.
  task automatic runCycles(input int n, output int nValid, output int nError,
                           output int firstValid, output int firstError);
    nValid = 0;
    nError = 0;
    firstValid = -1;
    firstError = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      if (valid_out === 1'b1) begin
        nValid++;
        if (firstValid < 0) firstValid = k;
      end
      if (error_out === 1'b1) begin
        nError++;
        if (firstError < 0) firstError = k;
      end
      if (valid_out === 1'b1 && error_out === 1'b1) bothCount++;
    end
  endtask

  // Reset state, then first report of "15" at the full latency.
  task automatic test_reset();
    int nV, nE, fV, fE;
    seg_msd_in = P1;
    seg_lsd_in = P5;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({msd_out, lsd_out, value_out, valid_out, error_out} !== 17'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {msd_out, lsd_out, value_out, valid_out, error_out});
    end
    @(negedge clock);
    reset = 1'b0;
    runCycles(40, nV, nE, fV, fE);
    checks++;
    if (nV !== 1) begin errors++; $display("[TB] FAIL first15_valid_count: got %0d expected 1", nV); end
    checks++;
    if (fV !== LATENCY) begin errors++; $display("[TB] FAIL first15_latency: got %0d expected %0d", fV, LATENCY); end
    checks++;
    if (nE !== 0) begin errors++; $display("[TB] FAIL first15_error_count: got %0d expected 0", nE); end
    checks++;
    if (value_out !== 7'd15) begin errors++; $display("[TB] FAIL first15_value: got %0d expected 15", value_out); end
    checks++;
    if (msd_out !== 4'd1) begin errors++; $display("[TB] FAIL first15_msd: got %0d expected 1", msd_out); end
    checks++;
    if (lsd_out !== 4'd5) begin errors++; $display("[TB] FAIL first15_lsd: got %0d expected 5", lsd_out); end
  endtask

  // "99" reports once and stays quiet while held.
  task automatic test_max_value();
    int nV, nE, fV, fE;
    applyStimulus(P9, P9);
    runCycles(40, nV, nE, fV, fE);
    checks++;
    if (nV !== 1 || fV !== LATENCY) begin
      errors++;
      $display("[TB] FAIL v99_report: got count %0d at %0d expected 1 at %0d", nV, fV, LATENCY);
    end
    checks++;
    if (value_out !== 7'b1100011) begin errors++; $display("[TB] FAIL v99_value: got %0d expected 99", value_out); end
    runCycles(100, nV, nE, fV, fE);
    checks++;
    if (nV !== 0 || nE !== 0) begin
      errors++;
      $display("[TB] FAIL v99_hold_quiet: got %0d valid %0d error expected 0 0", nV, nE);
    end
  endtask

  // Short glitch back to a reported value produces no pulse.
  task automatic test_glitch();
    int nV, nE, fV, fE;
    applyStimulus(P4, P2);
    runCycles(40, nV, nE, fV, fE);
    checks++;
    if (nV !== 1 || value_out !== 7'd42) begin
      errors++;
      $display("[TB] FAIL v42_report: got count %0d value %0d expected 1 42", nV, value_out);
    end
    applyStimulus(P4, P1);
    runCycles(9, nV, nE, fV, fE);
    checks++;
    if (nV !== 0 || nE !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_during: got %0d valid %0d error expected 0 0", nV, nE);
    end
    applyStimulus(P4, P2);
    runCycles(60, nV, nE, fV, fE);
    checks++;
    if (nV !== 0 || nE !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_restore: got %0d valid %0d error expected 0 0", nV, nE);
    end
    checks++;
    if (value_out !== 7'd42) begin errors++; $display("[TB] FAIL glitch_value: got %0d expected 42", value_out); end
  endtask

  // Blank tens digit reads as a leading zero.
  task automatic test_blank_msd();
    int nV, nE, fV, fE;
    applyStimulus(PBL, P3);
    runCycles(40, nV, nE, fV, fE);
    checks++;
    if (nV !== 1 || nE !== 0) begin
      errors++;
      $display("[TB] FAIL blank_msd_pulses: got %0d valid %0d error expected 1 0", nV, nE);
    end
    checks++;
    if (value_out !== 7'd3 || msd_out !== 4'd0 || lsd_out !== 4'd3) begin
      errors++;
      $display("[TB] FAIL blank_msd_value: got %0d/%0d/%0d expected 3/0/3", value_out, msd_out, lsd_out);
    end
  endtask

  // Illegal units patterns raise error only and keep the last value.
  task automatic test_illegal();
    int nV, nE, fV, fE;
    applyStimulus(PBL, PBL);
    runCycles(40, nV, nE, fV, fE);
    checks++;
    if (nE !== 1 || nV !== 0) begin
      errors++;
      $display("[TB] FAIL blank_lsd_pulses: got %0d error %0d valid expected 1 0", nE, nV);
    end
    checks++;
    if (value_out !== 7'd3) begin errors++; $display("[TB] FAIL blank_lsd_value: got %0d expected 3", value_out); end
    applyStimulus(PBL, PBAD);
    runCycles(40, nV, nE, fV, fE);
    checks++;
    if (nE !== 1 || nV !== 0 || fE !== LATENCY) begin
      errors++;
      $display("[TB] FAIL bad_lsd_pulses: got %0d error at %0d, %0d valid expected 1 at %0d, 0", nE, fE, nV, LATENCY);
    end
    checks++;
    if (value_out !== 7'd3 || lsd_out !== 4'd3) begin
      errors++;
      $display("[TB] FAIL bad_lsd_value: got %0d/%0d expected 3/3", value_out, lsd_out);
    end
  endtask

  // Reset mid-settle discards the pending report; pattern reports after release.
  task automatic test_reset_midway();
    int nV, nE, fV, fE;
    applyStimulus(P2, P7);
    runCycles(8, nV, nE, fV, fE);
    checks++;
    if (nV !== 0 || nE !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_pre: got %0d valid %0d error expected 0 0", nV, nE);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({msd_out, lsd_out, value_out, valid_out, error_out} !== 17'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %h expected 0",
               {msd_out, lsd_out, value_out, valid_out, error_out});
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    runCycles(40, nV, nE, fV, fE);
    checks++;
    if (nV !== 1 || fV !== LATENCY || nE !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_report: got %0d valid at %0d, %0d error expected 1 at %0d, 0", nV, fV, nE, LATENCY);
    end
    checks++;
    if (value_out !== 7'd27) begin errors++; $display("[TB] FAIL midreset_value: got %0d expected 27", value_out); end
  endtask

  // A bus showing "0" in both digits: value 0 still reported as valid.
  task automatic test_zero();
    int nV, nE, fV, fE;
    applyStimulus(P0, P0);
    runCycles(40, nV, nE, fV, fE);
    checks++;
    if (nV !== 1 || value_out !== 7'd0 || lsd_out !== 4'd0) begin
      errors++;
      $display("[TB] FAIL zero_report: got count %0d value %0d expected 1 0", nV, value_out);
    end
  endtask

  // Run the scenarios in sequence and summarise.
  initial begin
    checks = 0;
    errors = 0;
    bothCount = 0;
    reset = 1'b1;
    seg_msd_in = '0;
    seg_lsd_in = '0;
    test_reset();
    test_max_value();
    test_glitch();
    test_blank_msd();
    test_illegal();
    test_reset_midway();
    test_zero();
    checks++;
    if (bothCount !== 0) begin
      errors++;
      $display("[TB] FAIL valid_error_overlap: got %0d cycles expected 0", bothCount);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
